cdc_word_sync: RTL and testbench

Moves one W-bit word at a time from the a_clk domain to the b_clk domain using a four-phase req/ack handshake, with valid/ready flow control on both ends. It extends the pulse-level crossing to carry data and lets the b-side consumer stall the transfer. It sits between any a-domain producer and b-domain consumer that exchange low-rate control or configuration words.

---
 rtl/cdc_word_sync_if.sv | 25 ++
 rtl/cdc_word_sync.sv | 229 ++++++++++++++++++++++
 tb/tb_cdc_word_sync.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_word_sync_if.sv
// Bundle of the a-side producer and b-side consumer handshake signals of
// cdc_word_sync. The slave modport is the crossing block itself; the master
// modport is the producer/consumer pair that talks to it.
interface cdc_word_sync_if #(
  parameter int W = 32
);
  logic         a_valid;
  logic         a_ready;
  logic [W-1:0] a_data;
  logic         a_error;
  logic         b_valid;
  logic         b_ready;
  logic [W-1:0] b_data;
  logic         b_error;

  modport master (
    output a_valid, a_data, b_ready,
    input  a_ready, a_error, b_valid, b_data, b_error
  );

  modport slave (
    input  a_valid, a_data, b_ready,
    output a_ready, a_error, b_valid, b_data, b_error
  );
endinterface

// File: rtl/cdc_word_sync.sv
// cdc_word_sync: carries one W-bit word at a time from a_clk to b_clk using a
// four-phase req/ack handshake, with valid/ready flow control on both sides.
// Only the req and ack bits are synchronized; the held word crosses raw and is
// kept stable by the protocol from capture until the a-side sees ack fall.
// Optional feature macro: CDC_WORD_SYNC_ERROR_EN enables the sticky a_error /
// b_error flags (illegal one-hot encodings, B_VALID request drop). Without it
// both flags read 0 while the FSMs still recover to IDLE.

// Two-flop level synchronizer with synchronous active-high reset.
module cdc_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta_r;
  logic sync_r;

  // Resample the asynchronous level twice in the destination domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;
endmodule

module cdc_word_sync #(
  parameter int W = 32
) (
  input logic           a_clk,
  input logic           a_reset,
  input logic           b_clk,
  input logic           b_reset,
  cdc_word_sync_if.slave bus
);
  // One-hot state encodings for both sides.
  localparam logic [3:0] A_IDLE  = 4'b0001;
  localparam logic [3:0] A_REQ   = 4'b0010;
  localparam logic [3:0] A_DONE  = 4'b0100;
  localparam logic [3:0] A_ERR   = 4'b1000;
  localparam logic [3:0] B_IDLE  = 4'b0001;
  localparam logic [3:0] B_VALID = 4'b0010;
  localparam logic [3:0] B_ACK   = 4'b0100;
  localparam logic [3:0] B_ERR   = 4'b1000;

  logic [3:0]   a_state_r;
  logic [3:0]   a_state_next_s;
  logic [W-1:0] a_hold_r;
  logic         a_req_s;
  logic         a_ready_s;
  logic         a_accept_s;
  logic         a_ack_s;

  logic [3:0]   b_state_r;
  logic [3:0]   b_state_next_s;
  logic [W-1:0] b_data_r;
  logic         b_req_s;
  logic         b_ack_s;
  logic         b_valid_s;
  logic         b_capture_s;

  // ------------------------------------------------------------------ a side

  // A-side state register.
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      a_state_r <= A_IDLE;
    end else begin
      a_state_r <= a_state_next_s;
    end
  end

  // A-side next-state logic; anything unexpected falls back to IDLE.
  always_comb begin
    a_state_next_s = A_IDLE;
    case (a_state_r)
      A_IDLE: begin
        if (bus.a_valid) a_state_next_s = A_REQ;
        else             a_state_next_s = A_IDLE;
      end
      A_REQ: begin
        if (a_ack_s) a_state_next_s = A_DONE;
        else         a_state_next_s = A_REQ;
      end
      A_DONE: begin
        if (a_ack_s) a_state_next_s = A_DONE;
        else         a_state_next_s = A_IDLE;
      end
      A_ERR:   a_state_next_s = A_IDLE;
      default: a_state_next_s = A_IDLE;
    endcase
  end

  // A-side outputs: single-bit state decodes so req crosses glitch-free.
  always_comb begin
    a_ready_s  = a_state_r[0];
    a_req_s    = a_state_r[1];
    a_accept_s = (a_state_r == A_IDLE) && bus.a_valid;
  end

  // Capture the offered word on acceptance and hold it for the crossing.
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      a_hold_r <= {W{1'b0}};
    end else if (a_accept_s) begin
      a_hold_r <= bus.a_data;
    end else begin
      a_hold_r <= a_hold_r;
    end
  end

  // ------------------------------------------------------------ crossings

  cdc_sync u_req_sync (
    .clk   (b_clk),
    .reset (b_reset),
    .d     (a_req_s),
    .q     (b_req_s)
  );

  cdc_sync u_ack_sync (
    .clk   (a_clk),
    .reset (a_reset),
    .d     (b_ack_s),
    .q     (a_ack_s)
  );

  // ------------------------------------------------------------------ b side

  // B-side state register.
  always_ff @(posedge b_clk) begin
    if (b_reset) begin
      b_state_r <= B_IDLE;
    end else begin
      b_state_r <= b_state_next_s;
    end
  end

  // B-side next-state logic; a request dropped while offering is an error.
  always_comb begin
    b_state_next_s = B_IDLE;
    case (b_state_r)
      B_IDLE: begin
        if (b_req_s) b_state_next_s = B_VALID;
        else         b_state_next_s = B_IDLE;
      end
      B_VALID: begin
        if (!b_req_s)         b_state_next_s = B_ERR;
        else if (bus.b_ready) b_state_next_s = B_ACK;
        else                  b_state_next_s = B_VALID;
      end
      B_ACK: begin
        if (b_req_s) b_state_next_s = B_ACK;
        else         b_state_next_s = B_IDLE;
      end
      B_ERR:   b_state_next_s = B_IDLE;
      default: b_state_next_s = B_IDLE;
    endcase
  end

  // B-side outputs: single-bit state decodes so ack crosses glitch-free.
  always_comb begin
    b_valid_s   = b_state_r[1];
    b_ack_s     = b_state_r[2];
    b_capture_s = (b_state_r == B_IDLE) && b_req_s;
  end

  // Take the held word only on the IDLE->VALID step; it is stable by then.
  always_ff @(posedge b_clk) begin
    if (b_reset) begin
      b_data_r <= {W{1'b0}};
    end else if (b_capture_s) begin
      b_data_r <= a_hold_r;
    end else begin
      b_data_r <= b_data_r;
    end
  end

  assign bus.a_ready = a_ready_s;
  assign bus.b_valid = b_valid_s;
  assign bus.b_data  = b_data_r;

  // --------------------------------------------------------------- errors
`ifdef CDC_WORD_SYNC_ERROR_EN
  logic a_error_r;
  logic b_error_r;

  // True only for the four legal one-hot encodings of a 4-bit state.
  function automatic logic is_onehot4(input logic [3:0] s);
    return (s != 4'b0000) && ((s & (s - 4'b0001)) == 4'b0000);
  endfunction

  // Sticky a-side flag: entering A_ERR or sitting in an illegal encoding.
  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      a_error_r <= 1'b0;
    end else if (((a_state_next_s == A_ERR) && (a_state_r != A_ERR)) ||
                 !is_onehot4(a_state_r)) begin
      a_error_r <= 1'b1;
    end else begin
      a_error_r <= a_error_r;
    end
  end

  // Sticky b-side flag: entering B_ERR or sitting in an illegal encoding.
  always_ff @(posedge b_clk) begin
    if (b_reset) begin
      b_error_r <= 1'b0;
    end else if (((b_state_next_s == B_ERR) && (b_state_r != B_ERR)) ||
                 !is_onehot4(b_state_r)) begin
      b_error_r <= 1'b1;
    end else begin
      b_error_r <= b_error_r;
    end
  end

  assign bus.a_error = a_error_r;
  assign bus.b_error = b_error_r;
`else
  assign bus.a_error = 1'b0;
  assign bus.b_error = 1'b0;
`endif
endmodule

// File: tb/tb_cdc_word_sync.sv
// Self-checking bench for cdc_word_sync. A queue of words accepted on the
// a-side is the reference; a b-side monitor records every valid&ready
// handshake, and each test compares the two in order.
`timescale 1ns/1ps
module tb_cdc_word_sync;
  localparam int W = 32;
`ifdef CDC_WORD_SYNC_ERROR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic    a_clk   = 1'b0;
  logic    b_clk   = 1'b0;
  logic    a_reset = 1'b1;
  logic    b_reset = 1'b1;
  realtime a_half  = 5.0;
  realtime b_half  = 13.5;

  int checks = 0;
  int errors = 0;
  int b_ready_mode = 0;  // 0 low, 1 high, 2 random

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  cdc_word_sync_if #(.W(W)) bus ();

  cdc_word_sync #(.W(W)) dut (
    .a_clk   (a_clk),
    .a_reset (a_reset),
    .b_clk   (b_clk),
    .b_reset (b_reset),
    .bus     (bus)
  );

  // Free-running clocks; half periods are retuned per test.
  always #(a_half) a_clk = ~a_clk;
  always #(b_half) b_clk = ~b_clk;

  // Consumer: drive b_ready and log each word handed over on the next edge.
  always @(negedge b_clk) begin
    case (b_ready_mode)
      0:       bus.b_ready = 1'b0;
      1:       bus.b_ready = 1'b1;
      default: bus.b_ready = 1'($urandom_range(0, 1));
    endcase
    if (bus.b_valid === 1'b1 && bus.b_ready === 1'b1) got_q.push_back(bus.b_data);
  end

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #10000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    a_reset = 1'b1;
    b_reset = 1'b1;
    bus.a_valid = 1'b0;
    bus.a_data  = {W{1'b0}};
    repeat (4) @(posedge a_clk);
    repeat (4) @(posedge b_clk);
    @(negedge a_clk);
    a_reset = 1'b0;
    b_reset = 1'b0;
    repeat (3) @(negedge b_clk);
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic send_word(input logic [W-1:0] w);
    int n;
    n = 0;
    @(negedge a_clk);
    bus.a_valid = 1'b1;
    bus.a_data  = w;
    while (bus.a_ready !== 1'b1 && n < 3000) begin
      @(negedge a_clk);
      n++;
    end
    if (bus.a_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout actual a_ready=%b required 1 word=%h", bus.a_ready, w);
    end else begin
      exp_q.push_back(w);
    end
    @(posedge a_clk);
    #1;
    bus.a_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 20000) begin
      @(negedge b_clk);
      k++;
    end
    repeat (30) @(negedge b_clk);
  endtask

  task automatic wait_a_idle();
    int k;
    k = 0;
    while (bus.a_ready !== 1'b1 && k < 3000) begin
      @(negedge a_clk);
      k++;
    end
  endtask

  task automatic wait_b_valid(input logic level);
    int k;
    k = 0;
    while (bus.b_valid !== level && k < 500) begin
      @(negedge b_clk);
      k++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge a_clk);
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL rst_a_ready actual=%b required=1", bus.a_ready); end
    checks++; if (bus.a_error !== 1'b0) begin errors++; $display("FAIL rst_a_error actual=%b required=0", bus.a_error); end
    checks++; if (bus.b_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid actual=%b required=0", bus.b_valid); end
    checks++; if (bus.b_data !== {W{1'b0}}) begin errors++; $display("FAIL rst_b_data actual=%h required=0", bus.b_data); end
    checks++; if (bus.b_error !== 1'b0) begin errors++; $display("FAIL rst_b_error actual=%b required=0", bus.b_error); end
  endtask

  task automatic test_single();
    logic [W-1:0] g;
    a_half = 5.0; b_half = 13.5;
    do_reset();
    b_ready_mode = 1;
    send_word(32'hDEADBEEF);
    wait_got(1);
    wait_a_idle();
    g = (got_q.size() > 0) ? got_q[0] : {W{1'bx}};
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_count actual=%0d required=1", got_q.size()); end
    checks++; if (g !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data actual=%h required=deadbeef", g); end
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL single_a_ready actual=%b required=1", bus.a_ready); end
    checks++; if (bus.a_error !== 1'b0 || bus.b_error !== 1'b0) begin
      errors++; $display("FAIL single_errors actual=%b%b required=00", bus.a_error, bus.b_error);
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] w;
    logic [W-1:0] g;
    int bad;
    got_q.delete(); exp_q.delete();
    b_ready_mode = 0;
    w = $urandom;
    send_word(w);
    wait_b_valid(1'b1);
    checks++; if (bus.b_valid !== 1'b1) begin errors++; $display("FAIL stall_valid actual=%b required=1", bus.b_valid); end
    bad = 0;
    repeat (50) begin
      @(negedge b_clk);
      if (bus.b_valid !== 1'b1 || bus.b_data !== w || bus.a_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold actual=%0d_bad_cycles required=0 data=%h exp=%h", bad, bus.b_data, w); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL stall_early actual=%0d required=0", got_q.size()); end
    b_ready_mode = 1;
    wait_got(1);
    wait_a_idle();
    g = (got_q.size() > 0) ? got_q[0] : {W{1'bx}};
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL stall_count actual=%0d required=1", got_q.size()); end
    checks++; if (g !== w) begin errors++; $display("FAIL stall_data actual=%h required=%h", g, w); end
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL stall_a_ready actual=%b required=1", bus.a_ready); end
  endtask

  task automatic test_back_to_back(input realtime ah, input realtime bh);
    logic [W-1:0] base;
    a_half = ah; b_half = bh;
    repeat (4) @(negedge b_clk);
    got_q.delete(); exp_q.delete();
    b_ready_mode = 2;
    base = $urandom;
    for (int i = 0; i < 100; i++) send_word(base + W'(i));
    wait_got(100);
    checks++; if (got_q.size() != 100) begin errors++; $display("FAIL b2b_count actual=%0d required=100 ah=%0t", got_q.size(), ah); end
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_word[%0d] actual=%h required=%h", i,
                 (i < got_q.size()) ? got_q[i] : {W{1'bx}}, base + W'(i));
      end
    end
  endtask

  task automatic test_hold_changing();
    a_half = 5.0; b_half = 13.5;
    repeat (4) @(negedge b_clk);
    got_q.delete(); exp_q.delete();
    b_ready_mode = 2;
    @(negedge a_clk);
    bus.a_valid = 1'b1;
    repeat (400) begin
      bus.a_data = $urandom;
      if (bus.a_ready === 1'b1) exp_q.push_back(bus.a_data);
      @(negedge a_clk);
    end
    bus.a_valid = 1'b0;
    wait_got(exp_q.size());
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL hold_count actual=%0d required=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL hold_word[%0d] actual=%h required=%h", i,
                 (i < got_q.size()) ? got_q[i] : {W{1'bx}}, exp_q[i]);
      end
    end
  endtask

  task automatic test_a_reset_alone();
    logic [W-1:0] g;
    a_half = 5.0; b_half = 13.5;
    do_reset();
    b_ready_mode = 0;
    send_word($urandom);
    wait_b_valid(1'b1);
    checks++; if (bus.b_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid actual=%b required=1", bus.b_valid); end
    @(negedge a_clk);
    a_reset = 1'b1;
    repeat (2) @(negedge a_clk);
    a_reset = 1'b0;
    wait_b_valid(1'b0);
    repeat (2) @(negedge b_clk);
    checks++; if (bus.b_valid !== 1'b0) begin errors++; $display("FAIL arst_valid_drop actual=%b required=0", bus.b_valid); end
    checks++; if (bus.b_error !== EXP_ERR) begin errors++; $display("FAIL arst_b_error actual=%b required=%b", bus.b_error, EXP_ERR); end
    checks++; if (bus.a_error !== 1'b0) begin errors++; $display("FAIL arst_a_error actual=%b required=0", bus.a_error); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL arst_dropped actual=%0d required=0", got_q.size()); end
    exp_q.delete(); got_q.delete();
    b_ready_mode = 1;
    send_word(32'h0000_0001);
    wait_got(1);
    wait_a_idle();
    g = (got_q.size() > 0) ? got_q[0] : {W{1'bx}};
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL arst_next_count actual=%0d required=1", got_q.size()); end
    checks++; if (g !== 32'h0000_0001) begin errors++; $display("FAIL arst_next_data actual=%h required=00000001", g); end
  endtask

  task automatic test_force_b_state();
    logic [W-1:0] w;
    logic [W-1:0] g;
    a_half = 5.0; b_half = 13.5;
    do_reset();
    b_ready_mode = 1;
    checks++; if (bus.b_error !== 1'b0) begin errors++; $display("FAIL force_pre_err actual=%b required=0", bus.b_error); end
    @(negedge b_clk);
    force dut.b_state_r = 4'b0000;
    @(posedge b_clk);
    #1;
    checks++; if (bus.b_error !== EXP_ERR) begin errors++; $display("FAIL force_b_error actual=%b required=%b", bus.b_error, EXP_ERR); end
    checks++; if (bus.b_valid !== 1'b0) begin errors++; $display("FAIL force_b_valid actual=%b required=0", bus.b_valid); end
    @(negedge b_clk);
    release dut.b_state_r;
    @(posedge b_clk);
    #1;
    checks++; if (dut.b_state_r !== 4'b0001) begin errors++; $display("FAIL force_recover actual=%b required=0001", dut.b_state_r); end
    got_q.delete(); exp_q.delete();
    w = $urandom;
    send_word(w);
    wait_got(1);
    g = (got_q.size() > 0) ? got_q[0] : {W{1'bx}};
    checks++; if (g !== w || got_q.size() != 1) begin errors++; $display("FAIL force_next actual=%h/%0d required=%h/1", g, got_q.size(), w); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back(5.0, 15.0);
    test_back_to_back(15.0, 5.0);
    test_hold_changing();
    test_a_reset_alone();
    test_force_b_state();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
